// File: rtl/phase_iq_pkg.sv
// phase_iq_pkg: shared widths, quadrant encoding and dither LFSR constants for phase_iq
package phase_iq_pkg;
  localparam int PHW = 27;
  localparam int OFFW = 17;
  localparam int OFFSHIFT = 10;
  localparam int LFSR_W = 15;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 15'h6000;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;
  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_t;
endpackage

// File: rtl/quarter_sin_rom.sv
// quarter_sin_rom: dual-port registered quarter-wave sine ROM, L[k]=round(AMP*sin(pi/2*(k+0.5)/2^ADDRW)); ports clk, addr_a/addr_b -> data_a/data_b
module quarter_sin_rom #(
  parameter int ADDRW = 10,
  parameter int AMP = 32767
) (
  input  logic             clk,
  input  logic [ADDRW-1:0] addr_a,
  input  logic [ADDRW-1:0] addr_b,
  output logic [15:0]      data_a,
  output logic [15:0]      data_b
);
  function automatic logic [15:0] lval(int k);
    real x, t, s;
    x = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(2 ** ADDRW);
    t = x;
    s = x;
    for (int n = 1; n < 12; n++) begin
      t = -t * x * x / real'((2 * n) * (2 * n + 1));
      s = s + t;
    end
    return 16'($rtoi(real'(AMP) * s + 0.5));
  endfunction
  logic [15:0] rom [2**ADDRW];
  for (genvar k = 0; k < 2 ** ADDRW; k++) begin : g_rom
    assign rom[k] = lval(k);
  end
  always_ff @(posedge clk) begin
    data_a <= rom[addr_a];
    data_b <= rom[addr_b];
  end
endmodule

// File: rtl/phase_iq.sv
// phase_iq: phase+offset to signed cos/sin via quarter-wave ROM, 4-cycle latency; ports clk reset phasetime phvalid poffset pstrobe -> cos sin valid; PHASE_IQ_DITHER_EN adds LFSR dither
module phase_iq
  import phase_iq_pkg::*;
#(
  parameter int ADDRW = 10,
  parameter int AMP = 32767
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PHW-1:0]         phasetime,
  input  logic                   phvalid,
  input  logic [OFFW-1:0]        poffset,
  input  logic                   pstrobe,
  output logic signed [15:0]     cos,
  output logic signed [15:0]     sin,
  output logic                   valid
);
  logic [OFFW-1:0] offreg;
  logic [PHW-1:0] dith;
  logic [ADDRW+1:0] ph;
  logic [3:0] vd;
  quad_t q1, q2;
  logic [ADDRW-1:0] a, am;
  logic [15:0] la, lm;
`ifdef PHASE_IQ_DITHER_EN
  logic [LFSR_W-1:0] lfsr;
  always_ff @(posedge clk)
    lfsr <= reset ? LFSR_SEED : {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
  assign dith = PHW'(lfsr);
`else
  assign dith = '0;
`endif
  always_ff @(posedge clk) begin
    ph <= (ADDRW+2)'((phasetime + {offreg, OFFSHIFT'(0)} + dith) >> (PHW - ADDRW - 2));
    q1 <= quad_t'(ph[ADDRW+1:ADDRW]);
    a <= ph[ADDRW-1:0];
    am <= ~ph[ADDRW-1:0];
    q2 <= q1;
    if (reset) begin
      offreg <= '0;
      vd <= '0;
      cos <= '0;
      sin <= '0;
    end else begin
      if (pstrobe) offreg <= poffset;
      vd <= {vd[2:0], phvalid};
      sin <= q2 == Q0 ? la : q2 == Q1 ? lm : q2 == Q2 ? -la : -lm;
      cos <= q2 == Q0 ? lm : q2 == Q1 ? -la : q2 == Q2 ? -lm : la;
    end
  end
  assign valid = vd[3];
  quarter_sin_rom #(.ADDRW(ADDRW), .AMP(AMP)) u_rom (
    .clk(clk),
    .addr_a(a),
    .addr_b(am),
    .data_a(la),
    .data_b(lm)
  );
endmodule
